// File: rtl/race_pkg.sv
// ---------------------------------------------------------------------------
// race_pkg
// Shared constants, state encoding and small helpers for the race game.
//   LIGHT_GREEN / LIGHT_YELLOW / LIGHT_RED : 2-bit traffic light codes
//   race_state_t                            : top-level race FSM states
//   st_dq(n)                                : status code for a disqualified
//                                             lane in an n-player race
//   light_next(l)                           : GREEN -> YELLOW -> RED -> GREEN
// ---------------------------------------------------------------------------
package race_pkg;

    localparam logic [1:0] LIGHT_GREEN  = 2'b01;
    localparam logic [1:0] LIGHT_YELLOW = 2'b11;
    localparam logic [1:0] LIGHT_RED    = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RACE = 2'd1,
        DONE = 2'd2
    } race_state_t;

    // Ranks use 1..n, so the first free code above them marks disqualification.
    function automatic int st_dq(input int n);
        return n + 1;
    endfunction

    function automatic logic [1:0] light_next(input logic [1:0] l);
        logic [1:0] nxt;
        case (l)
            LIGHT_GREEN:  nxt = LIGHT_YELLOW;
            LIGHT_YELLOW: nxt = LIGHT_RED;
            default:      nxt = LIGHT_GREEN;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/race_lane.sv
// ---------------------------------------------------------------------------
// race_lane
// One player's lane: release detection, click counting, position and status.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   i_click           player button level
//   i_enable          race in progress (clicks ignored otherwise)
//   i_clear           start of a new race: zero pos/count/status
//   i_light           registered traffic light seen this cycle
//   i_max_clicks      extra releases needed per step
//   i_rank_in         rank to take if this lane finishes this cycle
//   o_pos             position, 0..TRACK_LEN
//   o_status          0 racing, 1..N rank, N+1 disqualified
//   o_finish_pulse    combinational: lane finishes on the coming edge
// ---------------------------------------------------------------------------
module race_lane
    import race_pkg::*;
#(
    parameter int N_PLAYERS = 4,
    parameter int TRACK_LEN = 8,
    parameter int CLICK_W   = 4,
    parameter int POS_W     = $clog2(TRACK_LEN + 1),
    parameter int ST_W      = $clog2(N_PLAYERS + 2)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_click,
    input  logic               i_enable,
    input  logic               i_clear,
    input  logic [1:0]         i_light,
    input  logic [CLICK_W-1:0] i_max_clicks,
    input  logic [ST_W-1:0]    i_rank_in,
    output logic [POS_W-1:0]   o_pos,
    output logic [ST_W-1:0]    o_status,
    output logic               o_finish_pulse
);

    localparam logic [ST_W-1:0] ST_DQ = ST_W'(st_dq(N_PLAYERS));

    logic               r_click_d;
    logic [CLICK_W-1:0] r_count;
    logic [POS_W-1:0]   r_pos;
    logic [ST_W-1:0]    r_status;

    logic w_release;
    logic w_active;
    logic w_step;

    assign w_release = r_click_d & ~i_click;
    assign w_active  = i_enable & w_release & (r_status == '0);
    assign w_step    = w_active & (i_light != LIGHT_RED) & (r_count >= i_max_clicks);

    assign o_finish_pulse = w_step & (r_pos == POS_W'(TRACK_LEN - 1));
    assign o_pos          = r_pos;
    assign o_status       = r_status;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_click_d <= 1'b0;
            r_count   <= '0;
            r_pos     <= '0;
            r_status  <= '0;
        end else begin
            // Edge register runs in every state so a held button never
            // produces a spurious release right after a race starts.
            r_click_d <= i_click;
            if (i_clear) begin
                r_count  <= '0;
                r_pos    <= '0;
                r_status <= '0;
            end else if (w_active) begin
                if (i_light == LIGHT_RED) begin
                    r_status <= ST_DQ;
                end else if (w_step) begin
                    r_count <= '0;
                    if (r_pos != POS_W'(TRACK_LEN))
                        r_pos <= r_pos + POS_W'(1);
                    if (o_finish_pulse)
                        r_status <= i_rank_in;
                end else begin
                    r_count <= r_count + CLICK_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/race_game_n.sv
// ---------------------------------------------------------------------------
// race_game_n
// N-player red-light/green-light click race controller: race FSM, finish
// rank allocation, traffic light, and a rotating single-lane display.
// Build option: RACE_AUTO_LIGHT_EN -- light steps every LIGHT_PERIOD cycles
// while racing instead of following i_light_toggle.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_start         level; starts a race when sampled high in IDLE/DONE
//   i_click         per-player button levels
//   i_max_clicks    extra releases per step
//   i_light_toggle  manual light advance button level
//   o_light         01 GREEN, 11 YELLOW, 10 RED
//   o_disp_sel      lane currently shown
//   o_disp_pos      thermometer of the shown lane's position
//   o_disp_status   status of the shown lane
//   o_race_done     high while in DONE
// ---------------------------------------------------------------------------
module race_game_n
    import race_pkg::*;
#(
    parameter int N_PLAYERS    = 4,
    parameter int TRACK_LEN    = 8,
    parameter int CLICK_W      = 4,
    parameter int DISP_W       = 8
`ifdef RACE_AUTO_LIGHT_EN
    ,
    parameter int LIGHT_PERIOD = 1024
`endif
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 i_start,
    input  logic [N_PLAYERS-1:0]                 i_click,
    input  logic [CLICK_W-1:0]                   i_max_clicks,
    input  logic                                 i_light_toggle,
    output logic [1:0]                           o_light,
    output logic [$clog2(N_PLAYERS)-1:0]         o_disp_sel,
    output logic [TRACK_LEN-1:0]                 o_disp_pos,
    output logic [$clog2(N_PLAYERS+2)-1:0]       o_disp_status,
    output logic                                 o_race_done
);

    localparam int SEL_W = $clog2(N_PLAYERS);
    localparam int ST_W  = $clog2(N_PLAYERS + 2);
    localparam int POS_W = $clog2(TRACK_LEN + 1);

    race_state_t         r_state;
    logic                r_race_done;
    logic [ST_W-1:0]     r_next_rank;
    logic [1:0]          r_light;
    logic [DISP_W-1:0]   r_disp_cnt;
    logic [SEL_W-1:0]    r_disp_sel;
    logic [TRACK_LEN-1:0] r_disp_pos;
    logic [ST_W-1:0]     r_disp_status;

    logic [POS_W-1:0]    w_pos     [N_PLAYERS];
    logic [ST_W-1:0]     w_status  [N_PLAYERS];
    logic [ST_W-1:0]     w_rank_in [N_PLAYERS];
    logic [N_PLAYERS-1:0] w_finish;
    logic [N_PLAYERS-1:0] w_lane_done;
    logic [ST_W-1:0]     w_finish_cnt;
    logic                w_in_race;
    logic                w_start_race;
    logic                w_all_done;
    logic [POS_W-1:0]    w_sel_pos;
    logic [TRACK_LEN-1:0] w_therm;

    assign w_in_race    = (r_state == RACE);
    assign w_start_race = i_start & (r_state != RACE);
    assign w_all_done   = &w_lane_done;

    // ---------------- lanes ----------------
    genvar gi;
    generate
        for (gi = 0; gi < N_PLAYERS; gi++) begin : g_lane
            race_lane #(
                .N_PLAYERS (N_PLAYERS),
                .TRACK_LEN (TRACK_LEN),
                .CLICK_W   (CLICK_W),
                .POS_W     (POS_W),
                .ST_W      (ST_W)
            ) u_lane (
                .clk            (clk),
                .rst            (rst),
                .i_click        (i_click[gi]),
                .i_enable       (w_in_race),
                .i_clear        (w_start_race),
                .i_light        (r_light),
                .i_max_clicks   (i_max_clicks),
                .i_rank_in      (w_rank_in[gi]),
                .o_pos          (w_pos[gi]),
                .o_status       (w_status[gi]),
                .o_finish_pulse (w_finish[gi])
            );
            assign w_lane_done[gi] = (w_status[gi] != '0);
        end
    endgenerate

    // Simultaneous finishers take consecutive ranks in lane-index order:
    // each lane's rank is next_rank plus the finishers below it.
    always_comb begin
        logic [ST_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < N_PLAYERS; i++) begin
            w_rank_in[i] = r_next_rank + acc;
            acc          = acc + ST_W'(w_finish[i]);
        end
        w_finish_cnt = acc;
    end

    // ---------------- race FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_race_done <= 1'b0;
            r_next_rank <= ST_W'(1);
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state     <= RACE;
                        r_next_rank <= ST_W'(1);
                    end
                end
                RACE: begin
                    r_next_rank <= r_next_rank + w_finish_cnt;
                    if (w_all_done) begin
                        r_state     <= DONE;
                        r_race_done <= 1'b1;
                    end
                end
                DONE: begin
                    if (i_start) begin
                        r_state     <= RACE;
                        r_race_done <= 1'b0;
                        r_next_rank <= ST_W'(1);
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_race_done <= 1'b0;
                end
            endcase
        end
    end

    // ---------------- traffic light ----------------
`ifdef RACE_AUTO_LIGHT_EN
    localparam int LT_W = (LIGHT_PERIOD > 1) ? $clog2(LIGHT_PERIOD) : 1;

    logic [LT_W-1:0] r_light_timer;
    logic            w_unused_toggle;

    assign w_unused_toggle = i_light_toggle;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_light       <= LIGHT_GREEN;
            r_light_timer <= '0;
        end else if (w_start_race) begin
            r_light       <= LIGHT_GREEN;
            r_light_timer <= '0;
        end else if (w_in_race) begin
            if (r_light_timer == LT_W'(LIGHT_PERIOD - 1)) begin
                r_light_timer <= '0;
                r_light       <= light_next(r_light);
            end else begin
                r_light_timer <= r_light_timer + LT_W'(1);
            end
        end
    end
`else
    logic r_toggle_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_light    <= LIGHT_GREEN;
            r_toggle_d <= 1'b0;
        end else begin
            r_toggle_d <= i_light_toggle;
            if (r_toggle_d & ~i_light_toggle)
                r_light <= light_next(r_light);
        end
    end
`endif

    // ---------------- display rotator ----------------
    assign w_sel_pos = w_pos[r_disp_sel];

    generate
        for (gi = 0; gi < TRACK_LEN; gi++) begin : g_therm
            assign w_therm[gi] = (w_sel_pos > POS_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp_cnt    <= '0;
            r_disp_sel    <= '0;
            r_disp_pos    <= '0;
            r_disp_status <= '0;
        end else begin
            r_disp_cnt <= r_disp_cnt + DISP_W'(1);
            if (&r_disp_cnt)
                r_disp_sel <= (r_disp_sel == SEL_W'(N_PLAYERS - 1)) ? '0
                                                                   : r_disp_sel + SEL_W'(1);
            r_disp_pos    <= w_therm;
            r_disp_status <= w_status[r_disp_sel];
        end
    end

    assign o_light       = r_light;
    assign o_disp_sel    = r_disp_sel;
    assign o_disp_pos    = r_disp_pos;
    assign o_disp_status = r_disp_status;
    assign o_race_done   = r_race_done;

endmodule

// File: tb/tb_race_game_n.sv
// ---------------------------------------------------------------------------
// tb_race_game_n
// Directed bench for race_game_n (N=4, TRACK_LEN=8, short display slots).
// Lane state is observed through the rotating display outputs.
// ---------------------------------------------------------------------------
module tb_race_game_n;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic [3:0] i_click;
    logic [3:0] i_max_clicks;
    logic       i_light_toggle;
    logic [1:0] o_light;
    logic [1:0] o_disp_sel;
    logic [7:0] o_disp_pos;
    logic [2:0] o_disp_status;
    logic       o_race_done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    race_game_n #(
        .N_PLAYERS    (4),
        .TRACK_LEN    (8),
        .CLICK_W      (4),
        .DISP_W       (2)
`ifdef RACE_AUTO_LIGHT_EN
        ,
        .LIGHT_PERIOD (4)
`endif
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_click        (i_click),
        .i_max_clicks   (i_max_clicks),
        .i_light_toggle (i_light_toggle),
        .o_light        (o_light),
        .o_disp_sel     (o_disp_sel),
        .o_disp_pos     (o_disp_pos),
        .o_disp_status  (o_disp_status),
        .o_race_done    (o_race_done)
    );

    // ---------------- stimulus / observation helpers ----------------
    task automatic release_lanes(input logic [3:0] mask);
        i_click = mask;
        @(negedge clk);
        i_click = 4'b0000;
        @(negedge clk);
    endtask

    task automatic release_n(input int lane, input int n);
        for (int j = 0; j < n; j++)
            release_lanes(4'(1 << lane));
    endtask

    task automatic toggle_light();
        i_light_toggle = 1'b1;
        @(negedge clk);
        i_light_toggle = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Wait until lane k is selected, then one more cycle for the registered view.
    task automatic read_lane(input int k, output logic [7:0] pos, output logic [2:0] st);
        int n;
        n = 0;
        while (o_disp_sel != 2'(k) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            total++;
            bad++;
            $display("FAIL read_lane%0d_timeout: disp_sel=%0d required=%0d", k, o_disp_sel, k);
        end
        @(negedge clk);
        pos = o_disp_pos;
        st  = o_disp_status;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst            = 1'b1;
        i_start        = 1'b0;
        i_click        = 4'b0000;
        i_max_clicks   = 4'd0;
        i_light_toggle = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (o_light !== 2'b01) begin bad++; $display("FAIL reset_light: got %b required 01", o_light); end
        total++; if (o_disp_sel !== 2'd0) begin bad++; $display("FAIL reset_sel: got %0d required 0", o_disp_sel); end
        total++; if (o_disp_pos !== 8'h00) begin bad++; $display("FAIL reset_pos: got %h required 00", o_disp_pos); end
        total++; if (o_disp_status !== 3'd0) begin bad++; $display("FAIL reset_status: got %0d required 0", o_disp_status); end
        total++; if (o_race_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b required 0", o_race_done); end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_start();
        pulse_start();
        @(negedge clk);
        total++; if (o_race_done !== 1'b0) begin bad++; $display("FAIL start_done: got %b required 0", o_race_done); end
        $display("test_start done");
    endtask

    task automatic test_max_clicks();
        logic [7:0] p;
        logic [2:0] s;
        i_max_clicks = 4'd2;
        release_n(1, 3);
        read_lane(1, p, s);
        total++; if (p !== 8'h01 || s !== 3'd0) begin bad++; $display("FAIL maxclk_3rel: pos=%h st=%0d required 01/0", p, s); end
        release_n(1, 2);
        read_lane(1, p, s);
        total++; if (p !== 8'h01) begin bad++; $display("FAIL maxclk_5rel: pos=%h required 01", p); end
        release_n(1, 1);
        read_lane(1, p, s);
        total++; if (p !== 8'h03) begin bad++; $display("FAIL maxclk_6rel: pos=%h required 03", p); end
        // switch to one release per step and bring lanes 1 and 3 to pos 7
        i_max_clicks = 4'd0;
        release_n(1, 5);
        release_n(3, 7);
        read_lane(1, p, s);
        total++; if (p !== 8'h7F || s !== 3'd0) begin bad++; $display("FAIL lane1_pos7: pos=%h st=%0d required 7f/0", p, s); end
        read_lane(3, p, s);
        total++; if (p !== 8'h7F || s !== 3'd0) begin bad++; $display("FAIL lane3_pos7: pos=%h st=%0d required 7f/0", p, s); end
        $display("test_max_clicks done");
    endtask

    task automatic test_light_dq();
        logic [7:0] p;
        logic [2:0] s;
        toggle_light();
        total++; if (o_light !== 2'b11) begin bad++; $display("FAIL light_yellow: got %b required 11", o_light); end
        // YELLOW behaves as GREEN
        release_n(0, 1);
        read_lane(0, p, s);
        total++; if (p !== 8'h01 || s !== 3'd0) begin bad++; $display("FAIL yellow_step: pos=%h st=%0d required 01/0", p, s); end
        toggle_light();
        total++; if (o_light !== 2'b10) begin bad++; $display("FAIL light_red: got %b required 10", o_light); end
        release_n(2, 1);
        read_lane(2, p, s);
        total++; if (s !== 3'd5 || p !== 8'h00) begin bad++; $display("FAIL red_dq: st=%0d pos=%h required 5/00", s, p); end
        toggle_light();
        total++; if (o_light !== 2'b01) begin bad++; $display("FAIL light_green: got %b required 01", o_light); end
        release_n(2, 2);
        read_lane(2, p, s);
        total++; if (s !== 3'd5 || p !== 8'h00) begin bad++; $display("FAIL dq_frozen: st=%0d pos=%h required 5/00", s, p); end
        $display("test_light_dq done");
    endtask

    task automatic test_simultaneous();
        logic [7:0] p;
        logic [2:0] s;
        release_lanes(4'b1010);
        read_lane(1, p, s);
        total++; if (s !== 3'd1 || p !== 8'hFF) begin bad++; $display("FAIL sim_lane1: st=%0d pos=%h required 1/ff", s, p); end
        read_lane(3, p, s);
        total++; if (s !== 3'd2 || p !== 8'hFF) begin bad++; $display("FAIL sim_lane3: st=%0d pos=%h required 2/ff", s, p); end
        total++; if (o_race_done !== 1'b0) begin bad++; $display("FAIL sim_done: got %b required 0", o_race_done); end
        $display("test_simultaneous done");
    endtask

    task automatic test_done();
        logic [7:0] p;
        logic [2:0] s;
        int n;
        release_n(0, 7);
        n = 0;
        while (!o_race_done && n < 10) begin
            @(negedge clk);
            n++;
        end
        total++; if (o_race_done !== 1'b1) begin bad++; $display("FAIL race_done: got %b required 1", o_race_done); end
        read_lane(0, p, s);
        total++; if (s !== 3'd3 || p !== 8'hFF) begin bad++; $display("FAIL lane0_rank3: st=%0d pos=%h required 3/ff", s, p); end
        $display("test_done done");
    endtask

    task automatic test_back_to_back();
        logic [7:0] p;
        logic [2:0] s;
        pulse_start();
        total++; if (o_race_done !== 1'b0) begin bad++; $display("FAIL restart_done: got %b required 0", o_race_done); end
        for (int k = 0; k < 4; k++) begin
            read_lane(k, p, s);
            total++;
            if (s !== 3'd0 || p !== 8'h00) begin
                bad++;
                $display("FAIL restart_lane%0d: st=%0d pos=%h required 0/00", k, s, p);
            end
        end
        release_n(0, 7);
        read_lane(0, p, s);
        total++; if (s !== 3'd0 || p !== 8'h7F) begin bad++; $display("FAIL r2_lane0_7: st=%0d pos=%h required 0/7f", s, p); end
        release_n(0, 1);
        read_lane(0, p, s);
        total++; if (s !== 3'd1 || p !== 8'hFF) begin bad++; $display("FAIL r2_lane0_rank1: st=%0d pos=%h required 1/ff", s, p); end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_mid_race();
        logic [7:0] p;
        logic [2:0] s;
        release_n(1, 1);
        toggle_light();
        #2 rst = 1'b1;
        #1;
        total++; if (o_light !== 2'b01) begin bad++; $display("FAIL midrst_light: got %b required 01", o_light); end
        total++; if (o_disp_sel !== 2'd0) begin bad++; $display("FAIL midrst_sel: got %0d required 0", o_disp_sel); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        // in IDLE clicks must be ignored
        release_n(1, 2);
        read_lane(1, p, s);
        total++; if (s !== 3'd0 || p !== 8'h00) begin bad++; $display("FAIL idle_ignored: st=%0d pos=%h required 0/00", s, p); end
        read_lane(0, p, s);
        total++; if (s !== 3'd0 || p !== 8'h00) begin bad++; $display("FAIL midrst_lane0: st=%0d pos=%h required 0/00", s, p); end
        $display("test_reset_mid_race done");
    endtask

`ifdef RACE_AUTO_LIGHT_EN
    task automatic test_auto_light();
        logic [1:0] exp_seq [4];
        exp_seq[0] = 2'b01;
        exp_seq[1] = 2'b11;
        exp_seq[2] = 2'b10;
        exp_seq[3] = 2'b01;
        pulse_start();
        for (int k = 0; k < 4; k++) begin
            if (k != 0) repeat (4) @(negedge clk);
            total++;
            if (o_light !== exp_seq[k]) begin
                bad++;
                $display("FAIL auto_light_%0d: got %b required %b", k, o_light, exp_seq[k]);
            end
        end
        repeat (4) @(negedge clk);
        total++; if (o_light !== 2'b11) begin bad++; $display("FAIL auto_light_4: got %b required 11", o_light); end
        #2 rst = 1'b1;
        #1;
        total++; if (o_light !== 2'b01) begin bad++; $display("FAIL auto_midrst: got %b required 01", o_light); end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        total++; if (o_light !== 2'b01) begin bad++; $display("FAIL auto_idle_frozen: got %b required 01", o_light); end
        $display("test_auto_light done");
    endtask
`endif

    initial begin
        test_reset();
`ifdef RACE_AUTO_LIGHT_EN
        test_auto_light();
`else
        test_start();
        test_max_clicks();
        test_light_dq();
        test_simultaneous();
        test_done();
        test_back_to_back();
        test_reset_mid_race();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
